madd_issue_ctrl: RTL
====================

// Module: madd_issue_ctrl
// PURPOSE
//   Upstream issue stage for multiply_add_seq. Buffers operand triples (a, b, c) from a
//   valid/ready producer and issues them one at a time to the engine via start/done.
//   Returns each 16-bit result a*b+c on a valid/ready output port.
//   Stays in order, with one operation in flight at a time.
// PARAMETERS
//   FIFO_DEPTH      4    operand FIFO entries; power of 2, >=2
//   TIMEOUT_CYCLES  64   watchdog limit in WAIT cycles; used only with MADD_ISSUE_TIMEOUT_EN
// PORTS
//   clk          in   1   single clock, rising edge
//   nrst         in   1   asynchronous active-low reset
//   in_valid     in   1   operand triple valid
//   in_ready     out  1   FIFO can accept; = !full
//   in_a/in_b    in   8   multiplicands, unsigned
//   in_c         in   8   addend, unsigned
//   mac_a/mac_b  out  8   to engine a/b; registered, stable ISSUE..RESULT
//   mac_constant out  8   to engine constant; registered
//   mac_start    out  1   one-cycle start pulse to engine
//   mac_done     in   1   engine completion, sampled only in WAIT
//   mac_o        in   16  engine result
//   out_valid    out  1   result available
//   out_ready    in   1   consumer accepts result
//   out_data     out  16  captured result
//   busy         out  1   high whenever state != IDLE
//   fifo_count   out  clog2(FIFO_DEPTH)+1   current FIFO occupancy
// BEHAVIOUR
// - Reset (async, nrst=0): all outputs go to 0 immediately, except in_ready, which is 1
//   after reset. FIFO is emptied, state=IDLE, mac_start=0. Reset mid-operation abandons
//   the in-flight op with no output.
// - FIFO push: on in_valid&&in_ready at a clk edge. in_ready comes from the registered
//   count. When full, no push occurs even if a pop happens in the same cycle.
// - FSM states: IDLE, ISSUE, WAIT, RESULT.
//   - IDLE: if count>0, pop the head, load mac_a/b/constant, and go to ISSUE.
//     Otherwise stay in IDLE.
//   - ISSUE: mac_start=1 for exactly this cycle, then go to WAIT.
//   - WAIT: mac_start=0. When mac_done=1, capture mac_o into out_data and go to RESULT.
//     mac_done is ignored in all other states.
//   - RESULT: out_valid=1 and out_data holds its value until out_ready=1, then go to IDLE.
// - Push and pop in the same cycle: count stays unchanged; pointers wrap modulo FIFO_DEPTH.
// - Latency: a triple pushed into an empty FIFO at edge k produces mac_start high in the
//   cycle after edge k+1. out_valid rises the cycle after the edge at which mac_done is seen.
// - Throughput: at most 1 op per (engine latency + 3) cycles. No issue while out_valid is held.
// - out_data is unchanged outside the RESULT capture. Width: 8x8+8 always fits in 16 bits,
//   so no truncation occurs.
// CONFIGURATION
//   MADD_ISSUE_TIMEOUT_EN defined:
//   - A WAIT cycle counter runs in WAIT.
//   - If TIMEOUT_CYCLES elapse without mac_done, go to RESULT with out_data=16'hFFFF.
//   - An extra output port, timeout_err, goes high with that result and drops on handshake.
//   MADD_ISSUE_TIMEOUT_EN undefined:
//   - No counter and no timeout_err port; WAIT waits indefinitely.
// TESTING
// 1. Single op: push (3,4,5); model engine 4-cycle latency -> one mac_start pulse with
//    mac_a=3/mac_b=4/mac_constant=5; out_valid with out_data=17.
// 2. Back-to-back: push (255,255,255), (0,0,0), (16,16,1) -> outputs 65280, 0, 257
//    in order; one mac_start per op.
// 3. Full: hold mac_done=0; offer 6 triples -> 5 accepted (1 in flight + 4 buffered);
//    in_ready=0 and fifo_count=4 on the 6th.
// 4. Output stall: out_ready=0 for 10 cycles -> out_valid and out_data stable;
//    no new mac_start until the handshake.
// 5. Reset mid-WAIT: assert nrst=0 -> busy=0, out_valid=0, mac_start=0 and fifo_count=0
//    immediately; after release, (2,3,1) -> 7.
// 6. (MADD_ISSUE_TIMEOUT_EN) never assert mac_done -> after 64 WAIT cycles, out_valid=1
//    with out_data=16'hFFFF and timeout_err=1; the next op proceeds normally.

Source files
------------

// File: rtl/madd_issue_ctrl.sv
// rtl/madd_issue_ctrl.sv - in-order operand FIFO and start/done issue FSM for multiply_add_seq
// Optional WAIT watchdog with timeout_err port: define MADD_ISSUE_TIMEOUT_EN.
module madd_issue_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [7:0]                  in_a,
  input  logic [7:0]                  in_b,
  input  logic [7:0]                  in_c,
  output logic [7:0]                  mac_a,
  output logic [7:0]                  mac_b,
  output logic [7:0]                  mac_constant,
  output logic                        mac_start,
  input  logic                        mac_done,
  input  logic [15:0]                 mac_o,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [15:0]                 out_data,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef MADD_ISSUE_TIMEOUT_EN
  ,
  output logic                        timeout_err
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("madd_issue_ctrl: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_t;

  state_t        state;
  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // in_ready depends only on the registered count, so a pop this cycle never frees a slot early
  assign in_ready = (fifo_count != CW'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b, in_c};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef MADD_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      mac_a        <= '0;
      mac_b        <= '0;
      mac_constant <= '0;
      mac_start    <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      busy         <= 1'b0;
`ifdef MADD_ISSUE_TIMEOUT_EN
      wait_cnt     <= '0;
      timeout_err  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            {mac_a, mac_b, mac_constant} <= mem[rd_ptr];
            mac_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mac_start <= 1'b0;
          state     <= WAIT;
`ifdef MADD_ISSUE_TIMEOUT_EN
          wait_cnt  <= '0;
`endif
        end
        WAIT: begin
          if (mac_done) begin
            out_data  <= mac_o;
            out_valid <= 1'b1;
            state     <= RESULT;
          end
`ifdef MADD_ISSUE_TIMEOUT_EN
          // the TIMEOUT_CYCLES-th WAIT cycle without done produces the error result
          else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            out_data    <= 16'hFFFF;
            out_valid   <= 1'b1;
            timeout_err <= 1'b1;
            state       <= RESULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESULT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
`ifdef MADD_ISSUE_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
